// File: rtl/rtc_apb_if.sv
// APB register front end for the RTC core: decodes bus transfers into core load strobes,
// returns live or snapshotted core state, and keeps sticky maskable interrupt status.
module rtc_apb_if (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [4:0]  paddr_i,
  input  logic [31:0] pwdata_i,
  input  logic        pwrite_i,
  input  logic        psel_i,
  input  logic        penable_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic        clock_update_o,
  output logic [21:0] clock_o,
  input  logic [21:0] clock_i,
  output logic [9:0]  init_sec_cnt_o,
  output logic        timer_update_o,
  output logic        timer_enable_o,
  output logic        timer_retrig_o,
  output logic [16:0] timer_target_o,
  input  logic [16:0] timer_value_i,
  output logic        alarm_enable_o,
  output logic        alarm_update_o,
  output logic [21:0] alarm_clock_o,
  input  logic [21:0] alarm_clock_i,
  output logic        date_update_o,
  output logic [31:0] date_o,
  input  logic [31:0] date_i,
  input  logic        event_i,
  input  logic        update_day_i,
  output logic        irq_o
);

  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_CLOCK     = 3'd1;
  localparam logic [2:0] ADDR_DATE      = 3'd2;
  localparam logic [2:0] ADDR_ALARM     = 3'd3;
  localparam logic [2:0] ADDR_TIMER_TGT = 3'd4;
  localparam logic [2:0] ADDR_TIMER_VAL = 3'd5;
  localparam logic [2:0] ADDR_INIT_SEC  = 3'd6;
  localparam logic [2:0] ADDR_STATUS    = 3'd7;

  logic [2:0]  addr;
  logic        setup_phase;
  logic        wr_access;
  logic [31:0] rdata_mux;
  logic        unused_addr_lsbs;

  logic [4:0]  ctrl_q,      ctrl_d;
  logic [21:0] clock_q,     clock_d;
  logic [31:0] date_q,      date_d;
  logic [21:0] alarm_q,     alarm_d;
  logic [16:0] tgt_q,       tgt_d;
  logic [9:0]  init_sec_q,  init_sec_d;
  logic [1:0]  status_q,    status_d;
  logic [31:0] date_snap_q, date_snap_d;
  logic [31:0] prdata_q,    prdata_d;
  logic        pslverr_q,   pslverr_d;
  logic        clock_upd_q, clock_upd_d;
  logic        date_upd_q,  date_upd_d;
  logic        alarm_upd_q, alarm_upd_d;
  logic        timer_upd_q, timer_upd_d;
  logic        irq_q,       irq_d;

  assign addr             = paddr_i[4:2];
  assign setup_phase      = psel_i & ~penable_i;
  assign wr_access        = psel_i & penable_i & pwrite_i;
  assign unused_addr_lsbs = ^paddr_i[1:0];

  always_comb begin
    rdata_mux = '0;
    case (addr)
      ADDR_CTRL:      rdata_mux = {27'b0, ctrl_q};
      ADDR_CLOCK:     rdata_mux = {10'b0, clock_i};
      ADDR_DATE:      rdata_mux = date_snap_q;
      ADDR_ALARM:     rdata_mux = {10'b0, alarm_clock_i};
      ADDR_TIMER_TGT: rdata_mux = {15'b0, tgt_q};
      ADDR_TIMER_VAL: rdata_mux = {15'b0, timer_value_i};
      ADDR_INIT_SEC:  rdata_mux = {22'b0, init_sec_q};
      default:        rdata_mux = {30'b0, status_q};
    endcase
  end

  always_comb begin
    ctrl_d      = ctrl_q;
    clock_d     = clock_q;
    date_d      = date_q;
    alarm_d     = alarm_q;
    tgt_d       = tgt_q;
    init_sec_d  = init_sec_q;
    status_d    = status_q;
    clock_upd_d = 1'b0;
    date_upd_d  = 1'b0;
    alarm_upd_d = 1'b0;
    timer_upd_d = 1'b0;
    if (wr_access) begin
      case (addr)
        ADDR_CTRL: begin
          ctrl_d      = pwdata_i[4:0];
          timer_upd_d = (pwdata_i[2:1] != ctrl_q[2:1]);
        end
        ADDR_CLOCK: begin
          clock_d     = {pwdata_i[21:16], 1'b0, pwdata_i[14:8], 1'b0, pwdata_i[6:0]};
          clock_upd_d = 1'b1;
        end
        ADDR_DATE: begin
          date_d     = pwdata_i;
          date_upd_d = 1'b1;
        end
        ADDR_ALARM: begin
          alarm_d     = pwdata_i[21:0];
          alarm_upd_d = 1'b1;
        end
        ADDR_TIMER_TGT: begin
          tgt_d       = pwdata_i[16:0];
          timer_upd_d = 1'b1;
        end
        ADDR_INIT_SEC: init_sec_d = pwdata_i[9:0];
        ADDR_STATUS:   status_d   = status_q & ~pwdata_i[1:0];
        default: ;
      endcase
    end
    // A new core pulse overrides a same-cycle write-1-to-clear.
    status_d = status_d | {update_day_i, event_i};

    prdata_d    = (setup_phase & ~pwrite_i) ? rdata_mux : '0;
    pslverr_d   = setup_phase & pwrite_i & (addr == ADDR_TIMER_VAL);
    date_snap_d = (setup_phase & ~pwrite_i & (addr == ADDR_CLOCK)) ? date_i : date_snap_q;
    irq_d       = (status_q[0] & ctrl_q[3]) | (status_q[1] & ctrl_q[4]);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ctrl_q      <= '0;
      clock_q     <= '0;
      date_q      <= '0;
      alarm_q     <= '0;
      tgt_q       <= '0;
      init_sec_q  <= 10'h3FF;
      status_q    <= '0;
      date_snap_q <= '0;
      prdata_q    <= '0;
      pslverr_q   <= 1'b0;
      clock_upd_q <= 1'b0;
      date_upd_q  <= 1'b0;
      alarm_upd_q <= 1'b0;
      timer_upd_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      clock_q     <= clock_d;
      date_q      <= date_d;
      alarm_q     <= alarm_d;
      tgt_q       <= tgt_d;
      init_sec_q  <= init_sec_d;
      status_q    <= status_d;
      date_snap_q <= date_snap_d;
      prdata_q    <= prdata_d;
      pslverr_q   <= pslverr_d;
      clock_upd_q <= clock_upd_d;
      date_upd_q  <= date_upd_d;
      alarm_upd_q <= alarm_upd_d;
      timer_upd_q <= timer_upd_d;
      irq_q       <= irq_d;
    end
  end

  assign prdata_o       = prdata_q;
  assign pready_o       = 1'b1;
  assign pslverr_o      = pslverr_q;
  assign clock_update_o = clock_upd_q;
  assign clock_o        = clock_q;
  assign init_sec_cnt_o = init_sec_q;
  assign timer_update_o = timer_upd_q;
  assign timer_enable_o = ctrl_q[1];
  assign timer_retrig_o = ctrl_q[2];
  assign timer_target_o = tgt_q;
  assign alarm_enable_o = ctrl_q[0];
  assign alarm_update_o = alarm_upd_q;
  assign alarm_clock_o  = alarm_q;
  assign date_update_o  = date_upd_q;
  assign date_o         = date_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_rtc_apb_if.sv
// Directed bench for rtc_apb_if: each task drives one scenario over APB and compares
// outputs against hand-computed values, sampling on the falling clock edge.
`timescale 1ns/1ps
module tb_rtc_apb_if;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic        pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        clock_update, timer_update, alarm_update, date_update;
  logic [21:0] clock_out, alarm_clock_out;
  logic [21:0] clock_in = '0, alarm_clock_in = '0;
  logic [9:0]  init_sec;
  logic        timer_enable, timer_retrig, alarm_enable;
  logic [16:0] timer_target;
  logic [16:0] timer_value = '0;
  logic [31:0] date_out;
  logic [31:0] date_in = '0;
  logic        event_in = 1'b0, update_day = 1'b0;
  logic        irq;
  logic [3:0]  strobes;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  logic        err;

  assign strobes = {clock_update, date_update, alarm_update, timer_update};

  rtc_apb_if dut (
    .clk_i(clk), .rstn_i(rstn), .paddr_i(paddr), .pwdata_i(pwdata),
    .pwrite_i(pwrite), .psel_i(psel), .penable_i(penable),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .clock_update_o(clock_update), .clock_o(clock_out), .clock_i(clock_in),
    .init_sec_cnt_o(init_sec), .timer_update_o(timer_update),
    .timer_enable_o(timer_enable), .timer_retrig_o(timer_retrig),
    .timer_target_o(timer_target), .timer_value_i(timer_value),
    .alarm_enable_o(alarm_enable), .alarm_update_o(alarm_update),
    .alarm_clock_o(alarm_clock_out), .alarm_clock_i(alarm_clock_in),
    .date_update_o(date_update), .date_o(date_out), .date_i(date_in),
    .event_i(event_in), .update_day_i(update_day), .irq_o(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Returns in the cycle after the access phase, where any strobe is visible.
  task automatic apb_write(input logic [4:0] a, input logic [31:0] d, output logic e);
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk); penable = 1'b1; e = pslverr;
    @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk); penable = 1'b1; d = prdata;
    @(negedge clk); psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (prdata !== 32'h0) begin errors++; $display("[TB] FAIL reset prdata: got %h, expected 0", prdata); end
    checks++; if (pready !== 1'b1) begin errors++; $display("[TB] FAIL reset pready: got %b, expected 1", pready); end
    checks++; if (pslverr !== 1'b0) begin errors++; $display("[TB] FAIL reset pslverr: got %b, expected 0", pslverr); end
    checks++; if (strobes !== 4'b0) begin errors++; $display("[TB] FAIL reset strobes: got %b, expected 0000", strobes); end
    checks++; if (init_sec !== 10'h3FF) begin errors++; $display("[TB] FAIL reset init_sec: got %h, expected 3ff", init_sec); end
    checks++; if ({clock_out, alarm_clock_out} !== 44'h0) begin errors++; $display("[TB] FAIL reset clock/alarm: got %h/%h, expected 0", clock_out, alarm_clock_out); end
    checks++; if ({date_out, timer_target} !== 49'h0) begin errors++; $display("[TB] FAIL reset date/target: got %h/%h, expected 0", date_out, timer_target); end
    checks++; if ({timer_enable, timer_retrig, alarm_enable, irq} !== 4'b0) begin errors++; $display("[TB] FAIL reset ctrl/irq: got %b, expected 0000", {timer_enable, timer_retrig, alarm_enable, irq}); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_writes;
    apb_write(5'h04, 32'h0012_3456, err);
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL clock pslverr: got %b, expected 0", err); end
    checks++; if (clock_out !== 22'h123456) begin errors++; $display("[TB] FAIL clock_o: got %h, expected 123456", clock_out); end
    checks++; if (strobes !== 4'b1000) begin errors++; $display("[TB] FAIL clock strobe: got %b, expected 1000", strobes); end
    @(negedge clk);
    checks++; if (strobes !== 4'b0000) begin errors++; $display("[TB] FAIL clock strobe width: got %b, expected 0000", strobes); end
    apb_write(5'h04, 32'hFFFF_FFFF, err);
    checks++; if (clock_out !== 22'h3F7F7F) begin errors++; $display("[TB] FAIL clock pad bits: got %h, expected 3f7f7f", clock_out); end
    apb_write(5'h08, 32'h2024_0315, err);
    checks++; if (date_out !== 32'h2024_0315) begin errors++; $display("[TB] FAIL date_o: got %h, expected 20240315", date_out); end
    checks++; if (strobes !== 4'b0100) begin errors++; $display("[TB] FAIL date strobe: got %b, expected 0100", strobes); end
    apb_write(5'h0C, 32'hFF23_5959, err);
    checks++; if (alarm_clock_out !== 22'h235959) begin errors++; $display("[TB] FAIL alarm_clock_o: got %h, expected 235959", alarm_clock_out); end
    checks++; if (strobes !== 4'b0010) begin errors++; $display("[TB] FAIL alarm strobe: got %b, expected 0010", strobes); end
    apb_write(5'h10, 32'h0001_FFFF, err);
    checks++; if (timer_target !== 17'h1FFFF) begin errors++; $display("[TB] FAIL timer_target_o: got %h, expected 1ffff", timer_target); end
    checks++; if (strobes !== 4'b0001) begin errors++; $display("[TB] FAIL timer strobe: got %b, expected 0001", strobes); end
    @(negedge clk);
    checks++; if (strobes !== 4'b0000) begin errors++; $display("[TB] FAIL timer strobe width: got %b, expected 0000", strobes); end
  endtask

  task automatic test_readback;
    clock_in = 22'h3AAAAA; alarm_clock_in = 22'h155555; timer_value = 17'h1A5A5;
    apb_read(5'h04, rd);
    checks++; if (rd !== 32'h003A_AAAA) begin errors++; $display("[TB] FAIL read clock: got %h, expected 003aaaaa", rd); end
    checks++; if (prdata !== 32'h0) begin errors++; $display("[TB] FAIL prdata idle: got %h, expected 0", prdata); end
    apb_read(5'h0C, rd);
    checks++; if (rd !== 32'h0015_5555) begin errors++; $display("[TB] FAIL read alarm: got %h, expected 00155555", rd); end
    apb_read(5'h14, rd);
    checks++; if (rd !== 32'h0001_A5A5) begin errors++; $display("[TB] FAIL read timer_val: got %h, expected 0001a5a5", rd); end
    apb_read(5'h13, rd);
    checks++; if (rd !== 32'h0001_FFFF) begin errors++; $display("[TB] FAIL read timer_tgt: got %h, expected 0001ffff", rd); end
    apb_write(5'h18, 32'hFFFF_F123, err);
    checks++; if (init_sec !== 10'h123) begin errors++; $display("[TB] FAIL init_sec_cnt_o: got %h, expected 123", init_sec); end
    checks++; if (strobes !== 4'b0000) begin errors++; $display("[TB] FAIL init_sec strobes: got %b, expected 0000", strobes); end
    apb_read(5'h18, rd);
    checks++; if (rd !== 32'h0000_0123) begin errors++; $display("[TB] FAIL read init_sec: got %h, expected 00000123", rd); end
    apb_read(5'h00, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL read ctrl: got %h, expected 0", rd); end
  endtask

  task automatic test_coherent_read;
    date_in = 32'hAAAA_0001;
    apb_read(5'h04, rd);
    date_in = 32'hBBBB_0002;
    apb_read(5'h08, rd);
    checks++; if (rd !== 32'hAAAA_0001) begin errors++; $display("[TB] FAIL date snapshot: got %h, expected aaaa0001", rd); end
  endtask

  task automatic test_interrupt;
    apb_write(5'h00, 32'h0000_0008, err);
    checks++; if (strobes !== 4'b0000) begin errors++; $display("[TB] FAIL ctrl irq_en strobes: got %b, expected 0000", strobes); end
    @(negedge clk); event_in = 1'b1;
    @(negedge clk); event_in = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq lag 1: got %b, expected 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq lag 2: got %b, expected 1", irq); end
    apb_read(5'h1C, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("[TB] FAIL status event: got %h, expected 1", rd); end
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h1C; pwdata = 32'h1;
    @(negedge clk); penable = 1'b1; event_in = 1'b1;
    @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0; event_in = 1'b0;
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq set-wins: got %b, expected 1", irq); end
    apb_read(5'h1C, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("[TB] FAIL status set-wins: got %h, expected 1", rd); end
    apb_write(5'h1C, 32'h1, err);
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq clear lag 1: got %b, expected 1", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq clear lag 2: got %b, expected 0", irq); end
    @(negedge clk); update_day = 1'b1;
    @(negedge clk); update_day = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq day masked: got %b, expected 0", irq); end
    apb_read(5'h1C, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("[TB] FAIL status day: got %h, expected 2", rd); end
    apb_write(5'h00, 32'h0000_0018, err);
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq day enabled: got %b, expected 1", irq); end
    apb_write(5'h1C, 32'h3, err);
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq day cleared: got %b, expected 0", irq); end
    apb_read(5'h1C, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL status cleared: got %h, expected 0", rd); end
    apb_write(5'h00, 32'h0, err);
  endtask

  task automatic test_slverr;
    apb_write(5'h14, 32'h0001_2345, err);
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL timer_val pslverr: got %b, expected 1", err); end
    checks++; if (strobes !== 4'b0000) begin errors++; $display("[TB] FAIL timer_val strobes: got %b, expected 0000", strobes); end
    checks++; if (pslverr !== 1'b0) begin errors++; $display("[TB] FAIL pslverr after: got %b, expected 0", pslverr); end
    checks++; if (timer_target !== 17'h1FFFF) begin errors++; $display("[TB] FAIL timer_val side effect: got %h, expected 1ffff", timer_target); end
  endtask

  task automatic test_ctrl_timer;
    apb_write(5'h00, 32'h0000_0002, err);
    checks++; if (strobes !== 4'b0001) begin errors++; $display("[TB] FAIL ctrl toggle strobe: got %b, expected 0001", strobes); end
    checks++; if (timer_enable !== 1'b1) begin errors++; $display("[TB] FAIL timer_enable_o: got %b, expected 1", timer_enable); end
    apb_write(5'h00, 32'h0000_0002, err);
    checks++; if (strobes !== 4'b0000) begin errors++; $display("[TB] FAIL ctrl same strobe: got %b, expected 0000", strobes); end
    apb_write(5'h00, 32'h0000_0003, err);
    checks++; if (strobes !== 4'b0000) begin errors++; $display("[TB] FAIL ctrl alarm-bit strobe: got %b, expected 0000", strobes); end
    checks++; if (alarm_enable !== 1'b1) begin errors++; $display("[TB] FAIL alarm_enable_o: got %b, expected 1", alarm_enable); end
    apb_write(5'h00, 32'h0000_0007, err);
    checks++; if ({strobes, timer_retrig} !== 5'b00011) begin errors++; $display("[TB] FAIL ctrl retrig: got %b, expected 00011", {strobes, timer_retrig}); end
  endtask

  task automatic test_reset_mid_transfer;
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h04; pwdata = 32'h0011_1111;
    @(negedge clk); penable = 1'b1;
    #2 rstn = 1'b0;
    @(negedge clk);
    checks++; if ({clock_update, clock_out} !== 23'h0) begin errors++; $display("[TB] FAIL mid reset clock: got %b/%h, expected 0/0", clock_update, clock_out); end
    checks++; if ({timer_enable, init_sec} !== 11'h3FF) begin errors++; $display("[TB] FAIL mid reset ctrl/init: got %b/%h, expected 0/3ff", timer_enable, init_sec); end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rstn = 1'b1;
    @(negedge clk);
    checks++; if (strobes !== 4'b0000) begin errors++; $display("[TB] FAIL post reset strobes: got %b, expected 0000", strobes); end
    apb_write(5'h04, 32'h0001_0203, err);
    checks++; if ({clock_update, clock_out} !== 23'h410203) begin errors++; $display("[TB] FAIL post reset write: got %b/%h, expected 1/010203", clock_update, clock_out); end
  endtask

  initial begin
    test_reset;
    test_writes;
    test_readback;
    test_coherent_read;
    test_interrupt;
    test_slverr;
    test_ctrl_timer;
    test_reset_mid_transfer;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_apb_if.md
# rtc_apb_if

APB register front end that initiates all configuration and readback traffic to the RTC core (clock, timer, alarm and date sub-blocks). It sits between the SoC peripheral bus and the RTC core, and converts APB transfers into the core's single-cycle update strobes and data buses. It returns live or snapshotted core state on reads. It also turns the core's event and day-rollover pulses into sticky, maskable interrupt status.

## Interface
- No parameters.
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- paddr_i  in  5  byte address, bits [4:2] decoded, [1:0] ignored.
- pwdata_i  in  32  write data.
- pwrite_i, psel_i, penable_i  in  1 each  APB control.
- prdata_o  out  32  read data.
- pready_o  out  1  constant 1.
- pslverr_o  out  1  error response.
- clock_update_o  out  1  one-cycle strobe, load clock_o into core.
- clock_o  out  22  time to load: hours BCD [21:16], minutes BCD [14:8], seconds BCD [6:0]; bits 15 and 7 written as 0.
- clock_i  in  22  live core time.
- init_sec_cnt_o  out  10  prescaler reload value.
- timer_update_o  out  1  one-cycle strobe.
- timer_enable_o, timer_retrig_o  out  1 each  timer controls.
- timer_target_o  out  17  timer target.
- timer_value_i  in  17  live timer count.
- alarm_enable_o  out  1  alarm control.
- alarm_update_o  out  1  one-cycle strobe.
- alarm_clock_o  out  22  alarm time.
- alarm_clock_i  in  22  core alarm readback.
- date_update_o  out  1  one-cycle strobe.
- date_o  out  32  date to load.
- date_i  in  32  live core date.
- event_i  in  1  core alarm/timer event pulse.
- update_day_i  in  1  core day-rollover pulse.
- irq_o  out  1  registered interrupt.

## Operation
- Address map (paddr_i[4:2]):
  - 0 CTRL RW: [0] alarm_enable, [1] timer_enable, [2] timer_retrig, [3] irq_en_event, [4] irq_en_day.
  - 1 CLOCK: W loads clock_o and pulses clock_update_o. R returns {10'b0, clock_i} and captures date_i into date_snap.
  - 2 DATE: W loads date_o and pulses date_update_o. R returns date_snap.
  - 3 ALARM: W loads alarm_clock_o and pulses alarm_update_o. R returns alarm_clock_i.
  - 4 TIMER_TGT: W loads timer_target_o and pulses timer_update_o. R returns the register.
  - 5 TIMER_VAL: RO, returns timer_value_i.
  - 6 INIT_SEC: RW, 10 bits.
  - 7 STATUS: [0] event_sticky, [1] day_sticky. Write 1 to clear.
- Writing CTRL with a change in bits [2:1] also pulses timer_update_o.
- A write to TIMER_VAL sets pslverr_o and has no side effect. All other addresses are valid.
- Unused read bits return 0. Write data bits beyond register width are dropped.
- Sticky status: set on event_i / update_day_i high.
  - If a set and a W1C occur in the same cycle, set wins.
- irq_o next = (event_sticky & irq_en_event) | (day_sticky & irq_en_day).
- Reset values:
  - all outputs 0, except init_sec_cnt_o = 10'h3FF and pready_o = 1;
  - date_snap = 0; status = 0.

## Timing
- Setup cycle: psel_i & ~penable_i.
  - prdata_o and pslverr_o are registered at the end of this cycle and held through the access cycle.
  - The date_snap capture on a CLOCK read happens at this same edge.
- Access cycle: psel_i & penable_i & pwrite_i.
  - The register is updated at the end of this cycle.
  - The matching strobe is high for exactly the following cycle, with its data output already valid.
- Zero wait states; every transfer completes in 2 cycles. Consecutive strobes to the core are therefore at least 2 cycles apart.
- prdata_o is 0 outside read transfers.
- irq_o lags the setting input pulse by 2 cycles and lags the W1C access by 2 cycles.
- Reset asserted mid-transfer: all state returns to reset values immediately, and a pending strobe is dropped. After deassertion, the bus restarts from idle.

## Test plan
- Reset: sample all outputs → all 0, except init_sec_cnt_o = 0x3FF and pready_o = 1; irq_o = 0.
- Write CLOCK with 0x0012_3456 → clock_o = 0x123456 with clock_update_o high for 1 cycle. Repeat for DATE 0x2024_0315, ALARM, TIMER_TGT 0x1FFFF, each with its own strobe only.
- Coherent read:
  - date_i = 0xAAAA_0001, then read CLOCK;
  - change date_i to 0xBBBB_0002, then read DATE → returns 0xAAAA_0001.
- Interrupt:
  - CTRL = 0x08, pulse event_i → STATUS = 1 and irq_o high 2 cycles later.
  - Write STATUS = 1 in the same cycle as a new event_i pulse → status stays 1.
  - Clear again → irq_o = 0.
- Write TIMER_VAL → pslverr_o = 1, no strobe.
- Write CTRL toggling bit1 → timer_update_o pulse. Rewrite the same value → no pulse.
- Assert rstn_i during the access phase of a CLOCK write → no clock_update_o, clock_o = 0.
